// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic light controller and its protocol monitor:
// phase encodings, fault codes, monitor states and the lamp decoder.
package traffic_pkg;

  // Phase encodings; the legal order is simply +1 modulo 4.
  localparam logic [1:0] PH_R  = 2'b00;
  localparam logic [1:0] PH_RA = 2'b01;
  localparam logic [1:0] PH_G  = 2'b10;
  localparam logic [1:0] PH_A  = 2'b11;

  // Fault causes reported by the monitor.
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TRANS   = 2'b10;
  localparam logic [1:0] ERR_DWELL   = 2'b11;

  // Monitor FSM states.
  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'd0,
    ST_LOCKED   = 2'd1,
    ST_FAULT    = 2'd2
  } mon_state_e;

  // Returns {legal, phase}. Illegal lamp patterns report phase R with legal=0.
  function automatic logic [2:0] decode_lamps(input logic red, input logic amber,
                                              input logic green);
    logic [2:0] result;
    case ({green, amber, red})
      3'b001:  result = {1'b1, PH_R};
      3'b011:  result = {1'b1, PH_RA};
      3'b100:  result = {1'b1, PH_G};
      3'b010:  result = {1'b1, PH_A};
      default: result = {1'b0, PH_R};
    endcase
    return result;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Saturating dwell counter: load forces the count to 1 (first sample of a new
// phase), inc adds one until the saturation value is reached.
module dwell_counter #(
  parameter int unsigned SAT = 16,
  parameter int unsigned W   = $clog2(SAT + 1)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] SAT_C = W'(SAT);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: load has priority, increment stops at the saturation value.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = W'(1);
    end else if (inc && (count_q != SAT_C)) begin
      count_d = count_q + W'(1);
    end
  end

  // Count register, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/traffic_monitor.sv
// In-circuit protocol monitor for the traffic light controller. Decodes the
// lamps every clock, checks the R -> RA -> G -> A -> R order and per-phase
// dwell bounds, counts completed cycles and latches the first fault.
module traffic_monitor
  import traffic_pkg::*;
#(
  parameter int unsigned DWELL_MIN = 1,
  parameter int unsigned DWELL_MAX = 15,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             red,
  input  logic             amber,
  input  logic             green,
  input  logic             check_en,
  output logic             locked,
  output logic [1:0]       phase,
  output logic             err,
  output logic [1:0]       err_code,
  output logic [CNT_W-1:0] cycles
);

  // Dwell must be able to represent DWELL_MAX+1, where it saturates.
  localparam int unsigned DW = $clog2(DWELL_MAX + 2);
  localparam logic [DW-1:0] DWELL_MIN_C = DW'(DWELL_MIN);
  localparam logic [DW-1:0] DWELL_MAX_C = DW'(DWELL_MAX);
  localparam logic [CNT_W-1:0] CYC_SAT = '1;

  mon_state_e       state_q, state_d;
  logic             locked_q, locked_d;
  logic [1:0]       phase_q, phase_d;
  logic             err_q, err_d;
  logic [1:0]       err_code_q, err_code_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  logic [2:0]       dec;
  logic             dec_legal;
  logic [1:0]       dec_phase;
  logic [DW-1:0]    dwell;
  logic             dwell_load;
  logic             dwell_inc;
  logic             fault;
  logic [1:0]       fault_code;

  assign dec       = decode_lamps(red, amber, green);
  assign dec_legal = dec[2];
  assign dec_phase = dec[1:0];

  dwell_counter #(
    .SAT (DWELL_MAX + 1),
    .W   (DW)
  ) u_dwell (
    .clk   (clk),
    .rst   (rst),
    .load  (dwell_load),
    .inc   (dwell_inc),
    .count (dwell)
  );

  // Sequence rules: next state, phase tracking, cycle count and fault capture.
  always_comb begin
    state_d    = state_q;
    phase_d    = phase_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    cycles_d   = cycles_q;
    dwell_load = 1'b0;
    dwell_inc  = 1'b0;
    fault      = 1'b0;
    fault_code = ERR_NONE;

    case (state_q)
      ST_UNLOCKED: begin
        if (check_en) begin
          if (dec_legal) begin
            state_d    = ST_LOCKED;
            phase_d    = dec_phase;
            dwell_load = 1'b1;
          end else begin
            fault      = 1'b1;
            fault_code = ERR_ILLEGAL;
          end
        end
      end

      ST_LOCKED: begin
        if (!check_en) begin
          // Disabling wins over anything seen on the lamps this sample.
          state_d = ST_UNLOCKED;
        end else if (!dec_legal) begin
          fault      = 1'b1;
          fault_code = ERR_ILLEGAL;
        end else if (dec_phase == phase_q) begin
          if (dwell >= DWELL_MAX_C) begin
            fault      = 1'b1;
            fault_code = ERR_DWELL;
          end else begin
            dwell_inc = 1'b1;
          end
        end else if (dec_phase == phase_q + 2'd1) begin
          if (dwell < DWELL_MIN_C) begin
            fault      = 1'b1;
            fault_code = ERR_DWELL;
          end else begin
            phase_d    = dec_phase;
            dwell_load = 1'b1;
            if ((phase_q == PH_A) && (cycles_q != CYC_SAT)) begin
              cycles_d = cycles_q + CNT_W'(1);
            end
          end
        end else begin
          fault      = 1'b1;
          fault_code = ERR_TRANS;
        end
      end

      ST_FAULT: begin
        // Absorbing until reset.
      end

      default: begin
        state_d = ST_UNLOCKED;
      end
    endcase

    if (fault) begin
      state_d = ST_FAULT;
      err_d   = 1'b1;
      if (err_code_q == ERR_NONE) begin
        err_code_d = fault_code;
      end
    end

    locked_d = (state_d == ST_LOCKED);
  end

  // State and registered outputs; reset clears all history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_UNLOCKED;
      locked_q   <= 1'b0;
      phase_q    <= PH_R;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      cycles_q   <= '0;
    end else begin
      state_q    <= state_d;
      locked_q   <= locked_d;
      phase_q    <= phase_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      cycles_q   <= cycles_d;
    end
  end

  assign locked   = locked_q;
  assign phase    = phase_q;
  assign err      = err_q;
  assign err_code = err_code_q;
  assign cycles   = cycles_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Scoreboard bench for traffic_monitor: two instances (default parameters and
// a tighter dwell / narrow counter variant) watch the same lamp stimulus.
module tb_traffic_monitor;

  localparam int A_MIN = 3;
  localparam int A_MAX = 5;
  localparam int A_CW  = 2;

  logic clk = 1'b0;
  logic rst;
  logic red, amber, green, check_en;

  logic       locked_d0, err_d0;
  logic [1:0] phase_d0, code_d0;
  logic [7:0] cycles_d0;
  logic       locked_d1, err_d1;
  logic [1:0] phase_d1, code_d1;
  logic [A_CW-1:0] cycles_d1;

  always #5 clk = ~clk;

  traffic_monitor u_def (
    .clk(clk), .rst(rst), .red(red), .amber(amber), .green(green),
    .check_en(check_en), .locked(locked_d0), .phase(phase_d0),
    .err(err_d0), .err_code(code_d0), .cycles(cycles_d0)
  );

  traffic_monitor #(.DWELL_MIN(A_MIN), .DWELL_MAX(A_MAX), .CNT_W(A_CW)) u_alt (
    .clk(clk), .rst(rst), .red(red), .amber(amber), .green(green),
    .check_en(check_en), .locked(locked_d1), .phase(phase_d1),
    .err(err_d1), .err_code(code_d1), .cycles(cycles_d1)
  );

  // Reference model: mode 0 unlocked, 1 locked, 2 faulted.
  typedef struct {
    int mode;
    int ph;
    int dwell;
    int err;
    int code;
    int cyc;
  } mdl_t;

  mdl_t m_def, m_alt;
  logic [13:0] q_def[$];
  logic [13:0] q_alt[$];
  int total = 0;
  int bad = 0;
  logic [2:0] lamp [4] = '{3'b001, 3'b011, 3'b100, 3'b010};

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m = '{mode: 0, ph: 0, dwell: 0, err: 0, code: 0, cyc: 0};
    return m;
  endfunction

  function automatic mdl_t fault_to(mdl_t m, int c);
    mdl_t r = m;
    r.mode = 2;
    r.err = 1;
    if (r.code == 0) r.code = c;
    return r;
  endfunction

  // One sample of the lamp protocol rules, gar = {green,amber,red}.
  function automatic mdl_t step(mdl_t m, logic [2:0] gar, bit en, int dmin, int dmax, int cmax);
    mdl_t r = m;
    int p = -1;
    for (int k = 0; k < 4; k++) if (lamp[k] == gar) p = k;
    if (r.mode == 2) return r;
    if (r.mode == 0) begin
      if (!en) return r;
      if (p < 0) return fault_to(r, 1);
      r.mode = 1; r.ph = p; r.dwell = 1;
      return r;
    end
    if (!en) begin r.mode = 0; return r; end
    if (p < 0) return fault_to(r, 1);
    if (p == r.ph) begin
      if (r.dwell + 1 > dmax) return fault_to(r, 3);
      r.dwell++;
      return r;
    end
    if (p == (r.ph + 1) % 4) begin
      if (r.dwell < dmin) return fault_to(r, 3);
      if (r.ph == 3 && r.cyc < cmax) r.cyc++;
      r.ph = p; r.dwell = 1;
      return r;
    end
    return fault_to(r, 2);
  endfunction

  function automatic logic [13:0] pack(mdl_t m);
    return {(m.mode == 1), 2'(m.ph), (m.err != 0), 2'(m.code), 8'(m.cyc)};
  endfunction

  task automatic compare(input string name, input logic [13:0] act, input logic [13:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got locked=%b phase=%b err=%b code=%b cycles=%0d need locked=%b phase=%b err=%b code=%b cycles=%0d",
               name, $time, act[13], act[12:11], act[10], act[9:8], act[7:0],
               exp[13], exp[12:11], exp[10], exp[9:8], exp[7:0]);
    end
  endtask

  function automatic logic [13:0] act_def();
    return {locked_d0, phase_d0, err_d0, code_d0, cycles_d0};
  endfunction

  function automatic logic [13:0] act_alt();
    return {locked_d1, phase_d1, err_d1, code_d1, 6'b0, cycles_d1};
  endfunction

  // Called at a falling edge: present one sample and queue the expected result.
  task automatic drive(input logic [2:0] gar, input bit en);
    {green, amber, red} = gar;
    check_en = en;
    m_def = step(m_def, gar, en, 1, 15, 255);
    m_alt = step(m_alt, gar, en, A_MIN, A_MAX, (1 << A_CW) - 1);
    q_def.push_back(pack(m_def));
    q_alt.push_back(pack(m_alt));
    $display("drive t=%0t gar=%b en=%b exp_def=%h exp_alt=%h", $time, gar, en, pack(m_def), pack(m_alt));
    @(negedge clk);
  endtask

  task automatic drive_n(input logic [2:0] gar, input bit en, input int n);
    for (int k = 0; k < n; k++) drive(gar, en);
  endtask

  // Called at a falling edge: async reset between edges, outputs must clear at once.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    m_def = mdl_reset();
    m_alt = mdl_reset();
    compare("reset_def", act_def(), pack(m_def));
    compare("reset_alt", act_alt(), pack(m_alt));
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Monitor: after each rising edge, compare against any queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (q_def.size() > 0) compare("seq_def", act_def(), q_def.pop_front());
      if (q_alt.size() > 0) compare("seq_alt", act_alt(), q_alt.pop_front());
    end
  end

  initial begin
    int wp;
    int hold;
    int r;
    logic [2:0] pat;
    bit en;

    rst = 1'b1;
    {green, amber, red} = 3'b000;
    check_en = 1'b0;
    m_def = mdl_reset();
    m_alt = mdl_reset();
    repeat (2) @(negedge clk);
    compare("por_def", act_def(), pack(m_def));
    compare("por_alt", act_alt(), pack(m_alt));
    rst = 1'b0;

    // One legal cycle, one sample per phase.
    drive(3'b001, 1); drive(3'b011, 1); drive(3'b100, 1); drive(3'b010, 1); drive(3'b001, 1);

    // Illegal encoding while locked, then a legal run must not overwrite the code.
    do_reset();
    drive_n(3'b001, 1, 3);
    drive(3'b111, 1);
    for (int k = 0; k < 10; k++) drive(lamp[k % 4], 1);

    // Wrong transition R -> G.
    do_reset();
    drive_n(3'b001, 1, 3);
    drive(3'b100, 1);

    // Dwell overflow: G held for 16 samples.
    do_reset();
    drive_n(3'b001, 1, 3);
    drive_n(3'b011, 1, 3);
    drive_n(3'b100, 1, 16);

    // Dwell too short: R held 2 samples then RA.
    do_reset();
    drive_n(3'b001, 1, 2);
    drive(3'b011, 1);

    // Enable dropped mid-sequence with garbage on the lamps, re-enabled at G.
    do_reset();
    drive_n(3'b001, 1, 3);
    drive_n(3'b010, 1, 0);
    drive_n(3'b011, 1, 3);
    drive_n(3'b100, 1, 2);
    drive_n(3'b111, 0, 3);
    drive_n(3'b100, 1, 3);
    drive_n(3'b010, 1, 3);
    drive_n(3'b001, 1, 3);

    // Five full cycles: narrow counter saturates at 3.
    do_reset();
    for (int c = 0; c < 5; c++)
      for (int k = 0; k < 4; k++) drive_n(lamp[k], 1, 3);
    drive_n(3'b001, 1, 3);
    do_reset();

    // Randomised traffic: mostly legal walking with random dwell, plus faults.
    wp = 0;
    hold = 3;
    for (int i = 0; i < 600; i++) begin
      if (i % 75 == 74) do_reset();
      r = $urandom_range(0, 99);
      pat = lamp[wp];
      en = 1'b1;
      if (r < 3) pat = 3'($urandom_range(0, 7));
      else if (r < 7) en = 1'b0;
      else if (r < 9) wp = (wp + 2) % 4;
      drive(pat, en);
      hold--;
      if (hold <= 0) begin
        wp = (wp + 1) % 4;
        hold = $urandom_range(1, 7);
      end
    end

    repeat (2) @(negedge clk);
    total++;
    if (q_def.size() != 0 || q_alt.size() != 0) begin
      bad++;
      $display("FAIL drain got pending=%0d need pending=0", q_def.size() + q_alt.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/traffic_monitor.md
# traffic_monitor

Synthesizable checker for the light outputs of the `traffic` controller. It samples `red`/`amber`/`green` every clock and decodes them into a phase. It verifies the legal UK sequence red → red+amber → green → amber → red, checks per-phase dwell bounds, counts completed cycles, and latches the first fault. It sits beside the controller, either in the top-level or in a bench, as an always-on, in-circuit protocol monitor.

## Interface
- `DWELL_MIN`, default 1: minimum consecutive cycles a phase must be held before it may change.
- `DWELL_MAX`, default 15: maximum consecutive cycles a phase may be held.
- `CNT_W`, default 8: width of the completed-cycle counter.
- `clk` in 1: single clock, rising-edge.
- `rst` in 1: reset, asynchronous and active-high.
- `red` in 1: red lamp from the controller.
- `amber` in 1: amber lamp.
- `green` in 1: green lamp.
- `check_en` in 1: monitoring enable; low forces resynchronisation.
- `locked` out 1: monitor is synchronised to a legal sequence.
- `phase` out 2: last decoded phase (00 R, 01 RA, 10 G, 11 A).
- `err` out 1: sticky fault flag.
- `err_code` out 2: first fault cause (00 none, 01 illegal encoding, 10 wrong transition, 11 dwell violation).
- `cycles` out CNT_W: completed A→R cycles, saturating at all-ones.

## Operation
- Decode `{green,amber,red}` as follows; every other pattern (000, 101, 110, 111) is illegal:
  - 001 → R
  - 011 → RA
  - 100 → G
  - 010 → A
- The expected next phase is `phase + 1` mod 4, so A (11) wraps to R (00).
- The FSM has three states: UNLOCKED, LOCKED and FAULT.
- UNLOCKED:
  - On a sample that is legal with `check_en`=1: load `phase`, set dwell=1, go to LOCKED.
  - On an illegal sample with `check_en`=1: go to FAULT with code 01.
  - With `check_en`=0: stay in UNLOCKED.
- LOCKED, evaluated each sample in priority order:
  1. `check_en`=0: go to UNLOCKED. `err`, `err_code` and `cycles` are preserved.
  2. Illegal encoding: FAULT with code 01.
  3. Same phase as before: dwell++. If dwell would exceed DWELL_MAX, FAULT with code 11.
  4. Phase equals the expected next phase:
     - If dwell < DWELL_MIN, FAULT with code 11.
     - Otherwise accept: update `phase`, set dwell=1, and increment `cycles` (saturating) if the transition was A→R.
  5. Any other phase: FAULT with code 10.
- FAULT:
  - `err`=1 and `locked`=0.
  - `err_code` holds the first cause; later faults do not overwrite it.
  - Exit only by `rst`; `check_en` has no effect.
- Width rules:
  - The dwell counter is wide enough for DWELL_MAX+1 and saturates there.
  - `cycles` never wraps.

## Timing
- All outputs are registered. A fault is reflected on the rising edge that samples the offending input, so it is visible one cycle after that input is presented.
- `locked` rises on the edge that samples the first legal phase with `check_en`=1.
- Asserting `rst` immediately (asynchronously) forces:
  - state=UNLOCKED
  - `locked`=0, `phase`=00, `err`=0, `err_code`=00, `cycles`=0
  - dwell=0
- Releasing `rst`: the first sample is taken on the next rising edge.
- Reset asserted mid-fault or mid-sequence clears everything; no history survives.
- Simultaneous events:
  - Illegal encoding together with `check_en` falling: `check_en` wins, no fault.
  - Dwell overflow and a phase change on the same sample cannot occur, because the change resets dwell.

## Structure
- Shared package `traffic_pkg` holds:
  - the phase localparams R/RA/G/A
  - the err_code localparams
  - a decode function returning {legal, phase[1:0]} from the lamp bits
- The same package is reused by the `traffic` controller.
- One sub-module, `dwell_counter` (saturating counter with load-to-1 and increment; exports count), keeps the FSM file focused on the sequence rules.

## Test plan
- Reset, `check_en`=1, drive 001, 011, 100, 010, 001 one cycle each (defaults) → `locked`=1 from the first edge, `err`=0, `cycles`=1 after the final edge, `phase`=00.
- Locked in R, drive 111 → `err`=1, `err_code`=01, `locked`=0. Then drive a legal sequence for 10 cycles → `err_code` stays 01.
- Locked in R (001), then drive 100 → `err_code`=10 on that edge.
- Hold 100 for 16 consecutive samples with DWELL_MAX=15 → no error through sample 15, `err_code`=11 on sample 16. With DWELL_MIN=3, R held 2 cycles then RA → `err_code`=11.
- Mid-sequence, drop `check_en` for 3 cycles, drive 111 meanwhile, re-enable at 100 → `locked` returns 1, `err`=0, `cycles` unchanged.
- CNT_W=2, run 5 full legal cycles → `cycles` reads 3. Assert `rst` between clock edges → all outputs zero before the next edge.
